// File: rtl/ex_div_pkg.sv
// Shared definitions for the execute-stage divider: op codes, FSM states, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ex_div_pkg;

  localparam int INST_REG_DATA = 32;
  localparam int INST_ADDR_W   = 5;

  // Divider op codes, allocated next to the ALU op space.
  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Two's-complement magnitude when neg is set, identity otherwise.
  function automatic logic [INST_REG_DATA-1:0] cond_neg(logic [INST_REG_DATA-1:0] v, logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Latency: 33 cycles start-edge to ready; divide-by-zero / signed overflow in 1 cycle.
// Backpressure: none; busy stalls the issuer, starts while busy are dropped, flush cancels.
module ex_div
  import ex_div_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     div_start_i,
  input  logic [1:0]               div_op_i,
  input  logic [INST_REG_DATA-1:0] div_dividend_i,
  input  logic [INST_REG_DATA-1:0] div_divisor_i,
  input  logic [INST_ADDR_W-1:0]   div_reg_waddr_i,
  input  logic                     div_flush_i,
  output logic                     div_busy_o,
  output logic                     div_ready_o,
  output logic [INST_REG_DATA-1:0] div_result_o,
  output logic [INST_ADDR_W-1:0]   div_reg_waddr_o
);

  div_state_e               state_q, state_d;
  div_op_e                  op_q, op_d;
  logic [INST_REG_DATA-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient
  logic [INST_REG_DATA-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [INST_REG_DATA-1:0] rem_q, rem_d;     // partial remainder
  logic [4:0]               cnt_q, cnt_d;
  logic                     negq_q, negq_d;   // quotient needs negation
  logic                     negr_q, negr_d;   // remainder needs negation
  logic [INST_ADDR_W-1:0]   waddr_q, waddr_d;
  logic [INST_REG_DATA-1:0] res_q, res_d;     // last completed result
  logic [INST_ADDR_W-1:0]   res_waddr_q, res_waddr_d;

  logic [INST_REG_DATA:0]   shifted;
  logic [INST_REG_DATA:0]   diff;
  logic [INST_REG_DATA-1:0] final_res;
  div_op_e                  op_in;
  logic                     sgn_in;

  assign op_in  = div_op_e'(div_op_i);
  assign sgn_in = op_is_signed(op_in);

  // Restoring step: shift one dividend bit into the remainder and trial-subtract.
  assign shifted   = {rem_q, dvd_q[INST_REG_DATA-1]};
  assign diff      = shifted - {1'b0, dvs_q};
  assign final_res = op_is_rem(op_q) ? cond_neg(rem_q, negr_q) : cond_neg(dvd_q, negq_q);

  // Flush kills the ready pulse in the same cycle, so the output mux follows it too.
  assign div_busy_o      = (state_q != S_IDLE);
  assign div_ready_o     = (state_q == S_DONE) && !div_flush_i;
  assign div_result_o    = div_ready_o ? final_res : res_q;
  assign div_reg_waddr_o = div_ready_o ? waddr_q : res_waddr_q;

  // Next-state and datapath update for all FSM states.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    waddr_d     = waddr_q;
    res_d       = res_q;
    res_waddr_d = res_waddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (div_start_i && !div_flush_i) begin
          op_d    = op_in;
          waddr_d = div_reg_waddr_i;
          cnt_d   = '0;
          if (div_divisor_i == '0) begin
            // Special results are preloaded so the common output path needs no extra mux.
            dvd_d   = '1;
            dvs_d   = '0;
            rem_d   = div_dividend_i;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_DONE;
          end else if (sgn_in && (div_dividend_i == 32'h8000_0000) && (div_divisor_i == '1)) begin
            dvd_d   = 32'h8000_0000;
            dvs_d   = div_divisor_i;
            rem_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            dvd_d   = cond_neg(div_dividend_i, sgn_in && div_dividend_i[INST_REG_DATA-1]);
            dvs_d   = cond_neg(div_divisor_i, sgn_in && div_divisor_i[INST_REG_DATA-1]);
            rem_d   = '0;
            negq_d  = sgn_in && (div_dividend_i[INST_REG_DATA-1] ^ div_divisor_i[INST_REG_DATA-1]);
            negr_d  = sgn_in && div_dividend_i[INST_REG_DATA-1];
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (div_flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = diff[INST_REG_DATA] ? shifted[INST_REG_DATA-1:0] : diff[INST_REG_DATA-1:0];
          dvd_d = {dvd_q[INST_REG_DATA-2:0], ~diff[INST_REG_DATA]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!div_flush_i) begin
          res_d       = final_res;
          res_waddr_d = waddr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_DIV;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      waddr_q     <= '0;
      res_q       <= '0;
      res_waddr_q <= '0;
    end else begin
      op_q        <= op_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      waddr_q     <= waddr_d;
      res_q       <= res_d;
      res_waddr_q <= res_waddr_d;
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: directed ops push expected results, a monitor checks ready pulses.
// Latency: checks 33-cycle normal and 1-cycle special-case ready timing.
// Backpressure: exercises ignored starts, flush in IDLE/CALC/DONE and reset mid-operation.
module tb_ex_div;
  import ex_div_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  wa;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start_i = 1'b0;
  logic [1:0]  div_op_i = 2'd0;
  logic [31:0] div_dividend_i = '0;
  logic [31:0] div_divisor_i = '0;
  logic [4:0]  div_reg_waddr_i = '0;
  logic        div_flush_i = 1'b0;
  logic        div_busy_o;
  logic        div_ready_o;
  logic [31:0] div_result_o;
  logic [4:0]  div_reg_waddr_o;

  ex_div dut (
    .clk             (clk),
    .rst             (rst),
    .div_start_i     (div_start_i),
    .div_op_i        (div_op_i),
    .div_dividend_i  (div_dividend_i),
    .div_divisor_i   (div_divisor_i),
    .div_reg_waddr_i (div_reg_waddr_i),
    .div_flush_i     (div_flush_i),
    .div_busy_o      (div_busy_o),
    .div_ready_o     (div_ready_o),
    .div_result_o    (div_result_o),
    .div_reg_waddr_o (div_reg_waddr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_pass = 0;
  int          n_total = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_res = '0;
  logic [4:0]  last_wa = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (div_ready_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'(div_ready_o), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", div_result_o, mon_e.res);
        check("waddr", {27'd0, div_reg_waddr_o}, {27'd0, mon_e.wa});
        check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (div_busy_o && n < 100);
    check("idle_reached", 32'(div_busy_o), 32'd0);
  endtask

  task automatic set_in(div_op_e op, logic [31:0] a, logic [31:0] b, logic [4:0] wa);
    div_op_i        = op;
    div_dividend_i  = a;
    div_divisor_i   = b;
    div_reg_waddr_i = wa;
  endtask

  task automatic do_op(div_op_e op, logic [31:0] a, logic [31:0] b, logic [4:0] wa,
                       logic [31:0] expv, int lat);
    @(posedge clk); #1;
    set_in(op, a, b, wa);
    div_start_i = 1'b1;
    sb.push_back('{res: expv, wa: wa, cyc: cyc + lat});
    @(posedge clk); #1;
    div_start_i = 1'b0;
    @(negedge clk);
    if (lat > 1) begin
      check("busy_in_calc", 32'(div_busy_o), 32'd1);
      check("result_held_in_calc", div_result_o, last_res);
    end
    wait_idle();
    check("result_held_after", div_result_o, expv);
    last_res = expv;
    last_wa  = wa;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(div_busy_o), 32'd0);
    check("rst_ready", 32'(div_ready_o), 32'd0);
    check("rst_result", div_result_o, 32'd0);
    check("rst_waddr", {27'd0, div_reg_waddr_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,          5'd5,  32'hFFFF_FFFD, 33);
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, 33);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10,         5'd7,  32'h0FFF_FFFF, 33);
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'h10,         5'd8,  32'h0000_000F, 33);
    do_op(OP_DIV,  32'd100,       32'd0,          5'd9,  32'hFFFF_FFFF, 1);
    do_op(OP_REM,  32'd100,       32'd0,          5'd10, 32'd100,       1);
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  5'd11, 32'h8000_0000, 1);
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  5'd12, 32'd0,         1);
    do_op(OP_DIVU, 32'd7,         32'd0,          5'd13, 32'hFFFF_FFFF, 1);
    do_op(OP_REMU, 32'd7,         32'd0,          5'd14, 32'd7,         1);
    do_op(OP_DIV,  32'hFFFF_FF9C, 32'd7,          5'd15, 32'hFFFF_FFF2, 33);
    do_op(OP_REM,  32'hFFFF_FF9C, 32'd7,          5'd16, 32'hFFFF_FFFE, 33);
    do_op(OP_DIV,  32'd100,       32'hFFFF_FFF9,  5'd17, 32'hFFFF_FFF2, 33);
    do_op(OP_REM,  32'd100,       32'hFFFF_FFF9,  5'd18, 32'd2,         33);
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  5'd19, 32'd0,         33);
    do_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF,  5'd20, 32'h8000_0000, 33);

    // Flush mid-CALC, with a second start dropped while busy.
    @(posedge clk); #1;
    set_in(OP_DIVU, 32'd1000, 32'd7, 5'd21);
    div_start_i = 1'b1;
    @(posedge clk); #1;
    div_start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    set_in(OP_DIV, 32'd100, 32'd0, 5'd3);
    div_start_i = 1'b1;
    @(posedge clk); #1;
    div_start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    div_flush_i = 1'b1;
    @(posedge clk); #1;
    div_flush_i = 1'b0;
    @(negedge clk);
    check("flush_calc_busy", 32'(div_busy_o), 32'd0);
    check("flush_calc_result", div_result_o, last_res);
    check("flush_calc_waddr", {27'd0, div_reg_waddr_o}, {27'd0, last_wa});
    repeat (40) @(negedge clk);
    check("flush_calc_stays_idle", 32'(div_busy_o), 32'd0);

    // Start and flush together in IDLE: flush wins.
    @(posedge clk); #1;
    set_in(OP_DIV, 32'd5, 32'd0, 5'd4);
    div_start_i = 1'b1;
    div_flush_i = 1'b1;
    @(posedge clk); #1;
    div_start_i = 1'b0;
    div_flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 32'(div_busy_o), 32'd0);

    // Flush in DONE suppresses the ready pulse and the result update.
    @(posedge clk); #1;
    set_in(OP_DIV, 32'd5, 32'd0, 5'd4);
    div_start_i = 1'b1;
    @(posedge clk); #1;
    div_start_i = 1'b0;
    div_flush_i = 1'b1;
    @(negedge clk);
    check("flush_done_ready", 32'(div_ready_o), 32'd0);
    check("flush_done_result", div_result_o, last_res);
    @(posedge clk); #1;
    div_flush_i = 1'b0;
    @(negedge clk);
    check("flush_done_busy", 32'(div_busy_o), 32'd0);
    check("flush_done_result_after", div_result_o, last_res);

    do_op(OP_DIVU, 32'd1000, 32'd7, 5'd22, 32'd142, 33);

    // Reset mid-CALC clears everything immediately.
    @(posedge clk); #1;
    set_in(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 5'd23);
    div_start_i = 1'b1;
    @(posedge clk); #1;
    div_start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(div_busy_o), 32'd0);
    check("midrst_ready", 32'(div_ready_o), 32'd0);
    check("midrst_result", div_result_o, 32'd0);
    check("midrst_waddr", {27'd0, div_reg_waddr_o}, 32'd0);
    last_res = '0;
    last_wa  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_resume", 32'(div_busy_o), 32'd0);

    do_op(OP_DIVU, 32'd10, 32'd3, 5'd24, 32'd3, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 Parameters: none; data width 32 (INST_REG_DATA), register address width 5 (INST_ADDR width of register file).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 div_start_i  input  1  request a divide; sampled only in IDLE.
REQ-005 div_op_i  input  2  operation: DIV, DIVU, REM, REMU (codes in shared defines).
REQ-006 div_dividend_i  input  32  rs1 operand.
REQ-007 div_divisor_i  input  32  rs2 operand.
REQ-008 div_reg_waddr_i  input  5  destination register of the request.
REQ-009 div_flush_i  input  1  cancel in-flight operation (branch/jump flush).
REQ-010 div_busy_o  output  1  high while an operation is in flight; execute stage stalls on it.
REQ-011 div_ready_o  output  1  one-cycle pulse: result valid.
REQ-012 div_result_o  output  32  quotient or remainder per captured op.
REQ-013 div_reg_waddr_o  output  5  captured destination register, valid with div_ready_o.

Function
REQ-014 FSM states: IDLE, CALC, DONE; div_busy_o = (state != IDLE), registered state only.
REQ-015 IDLE: div_start_i=1 and div_flush_i=0 captures op, operands, waddr at the edge; divisor==0 or signed overflow -> DONE, else CALC with iteration counter=0.
REQ-016 CALC: radix-2 restoring divide on 32-bit magnitudes, one quotient bit per cycle, exactly 32 cycles, then DONE.
REQ-017 DONE: div_ready_o=1 for exactly one cycle, next edge -> IDLE; normal-path latency 33 cycles from the start-sampling edge to ready, special cases 1 cycle.
REQ-018 DIV/REM: magnitudes of operands used; quotient negated when operand signs differ; remainder takes dividend sign.
REQ-019 DIVU/REMU: operands treated unsigned, no sign correction.
REQ-020 Divide by zero: quotient 0xFFFFFFFF (all ops), remainder = dividend (all ops).
REQ-021 Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
REQ-022 div_start_i while busy is ignored; no queueing.
REQ-023 div_flush_i in CALC or DONE: next edge -> IDLE, div_ready_o not asserted (suppressed combinationally in DONE).
REQ-024 div_start_i and div_flush_i in same IDLE cycle: flush wins, no capture.
REQ-025 div_result_o and div_reg_waddr_o hold last completed values until the next DONE; not updated by flushed operations.

Reset
REQ-026 rst=1 asynchronously forces state IDLE, counter 0, div_busy_o=0, div_ready_o=0, div_result_o=0, div_reg_waddr_o=0, all datapath registers 0.
REQ-027 Reset during CALC/DONE abandons the operation; no ready pulse after release.

Structure
REQ-028 Op codes (DIV, DIVU, REM, REMU) and FSM state encodings live in defines.v alongside the ALU op codes.
REQ-029 Single module; no sub-module is natural (datapath is one shift/subtract register set).

Verification
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> ready 33 cycles after start, result 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-031 DIVU 0xFFFFFFFF / 0x00000010 -> 0x0FFFFFFF; REMU -> 0x0000000F.
REQ-032 DIV 100 / 0 -> ready 1 cycle after start, 0xFFFFFFFF; REM 100 / 0 -> 100.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 cycle; REM -> 0.
REQ-034 Start, flush at cycle 10 -> busy drops next edge, no ready pulse, div_result_o unchanged; second start during CALC ignored.
REQ-035 Assert rst mid-CALC -> outputs 0 immediately; after release, new DIVU 10/3 -> 3 in 33 cycles.
